seq_sched: RTL and testbench

SEQ_SCHED -- requirements
Module: seq_sched

---
 rtl/seq_sched.sv | 123 ++++++++++++
 tb/tb_seq_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_sched.sv
// Pattern-table sequencer: plays table[0..len] loops times (0 = until stop) as a valid/ready stream.
// First symbol is valid one cycle after start; out/out_valid hold while out_ready is low.
module seq_sched #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [2:0]   len,
  input  logic [3:0]   loops,
  input  logic         start,
  input  logic         stop,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [W-1:0] r_table [DEPTH];
  logic [W-1:0] r_out;
  logic         r_out_valid;
  logic [2:0]   r_idx;
  logic [3:0]   r_pass;
  logic [2:0]   r_len_q;
  logic [3:0]   r_loops_q;

  logic         w_xfer;
  logic         w_last;
  logic         w_final;
  logic [2:0]   w_idx_inc;

  assign w_xfer    = r_out_valid & out_ready;
  assign w_last    = (r_idx == r_len_q);
  assign w_final   = w_last && (r_loops_q != 4'd0) && (r_pass == r_loops_q);
  assign w_idx_inc = r_idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Stop wins over a normal end-of-sequence on the same edge; both land in DONE.
        if (stop || (w_xfer && w_final)) w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_idx       <= 3'd0;
      r_pass      <= 4'd0;
      r_len_q     <= 3'd0;
      r_loops_q   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wr_en) r_table[wr_addr] <= wr_data;
          // r_table[0] is sampled before the same-edge write lands.
          if (start && !stop) begin
            r_len_q     <= len;
            r_loops_q   <= loops;
            r_idx       <= 3'd0;
            r_pass      <= 4'd1;
            r_out       <= r_table[0];
            r_out_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_out_valid <= 1'b0;
          end else if (w_xfer) begin
            if (!w_last) begin
              r_idx <= w_idx_inc;
              r_out <= r_table[w_idx_inc];
            end else if (w_final) begin
              r_out_valid <= 1'b0;
            end else begin
              r_idx  <= 3'd0;
              r_out  <= r_table[0];
              r_pass <= r_pass + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_sched.sv
// Directed bench for seq_sched: inputs change 1ns after the rising edge, outputs sampled there too.
module tb_seq_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [2:0] len;
  logic [3:0] loops;
  logic       start;
  logic       stop;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  seq_sched #(.W(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .loops     (loops),
    .start     (start),
    .stop      (stop),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; len = 0; loops = 0;
    start = 0; stop = 0; out_ready = 0;
    #2;
    checks++; if (out !== 4'd0) begin failures++; $display("FAIL reset_out got=%0h exp=0", out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] e [8];
    e = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    wr(0, 4'h1); wr(1, 4'h2); wr(2, 4'h4); wr(3, 4'h8);
    len = 3; loops = 2; out_ready = 1; start = 1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_prestart_valid got=%0b exp=0", out_valid); end
    tick();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b1 || out !== e[i]) begin failures++; $display("FAIL basic_sym%0d got=%0h/v%0b exp=%0h/v1", i, out, out_valid, e[i]); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy%0d got=%0b exp=1", i, busy); end
      tick();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%0b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_end got=%0b exp=0", out_valid); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle got=%0b exp=0", done); end
    checks++; if (out !== 4'h8) begin failures++; $display("FAIL basic_out_retained got=%0h exp=8", out); end
  endtask

  task automatic test_ready_toggle();
    logic [3:0] e [8];
    int n;
    bit seen;
    e = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    n = 0; seen = 0;
    len = 3; loops = 2; start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      out_ready = (c % 2 == 0);
      if (out_valid) begin
        if (n < 8) begin
          checks++; if (out !== e[n]) begin failures++; $display("FAIL toggle_sym cyc=%0d got=%0h exp=%0h", c, out, e[n]); end
        end else begin
          checks++; failures++; $display("FAIL toggle_extra_valid cyc=%0d got=v1 exp=v0", c);
        end
        if (out_ready) n++;
      end
      tick();
      if (done) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL toggle_done_timeout got=0 exp=1"); end
    checks++; if (n !== 8) begin failures++; $display("FAIL toggle_xfer_count got=%0d exp=8", n); end
    out_ready = 1;
    tick();
  endtask

  task automatic test_stop();
    wr(0, 4'h5); wr(1, 4'hA);
    len = 1; loops = 0; out_ready = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 7; i++) begin
      checks++; if (out_valid !== 1'b1 || out !== ((i % 2) ? 4'hA : 4'h5)) begin failures++; $display("FAIL stop_sym%0d got=%0h/v%0b exp=%0h/v1", i, out, out_valid, (i % 2) ? 4'hA : 4'h5); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out !== 4'hA) begin failures++; $display("FAIL stop_still_running got=%0h/v%0b exp=a/v1", out, out_valid); end
    stop = 1; out_ready = 0;
    tick();
    stop = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stop_valid got=%0b exp=0", out_valid); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL stop_done got=d%0b/b%0b exp=d1/b0", done, busy); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_idle got=d%0b/b%0b exp=d0/b0", done, busy); end
  endtask

  task automatic test_wr_in_run();
    len = 3; loops = 1; out_ready = 0; start = 1;
    tick();
    start = 0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wrrun_busy got=%0b exp=1", busy); end
    wr(0, 4'hF);
    stop = 1;
    tick();
    stop = 0;
    tick();
    len = 0; loops = 1; out_ready = 1; start = 1;
    wr_en = 1; wr_addr = 0; wr_data = 4'h7;
    tick();
    start = 0; wr_en = 0;
    checks++; if (out !== 4'h5 || out_valid !== 1'b1) begin failures++; $display("FAIL wrrun_orig_t0 got=%0h/v%0b exp=5/v1", out, out_valid); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrrun_done got=%0b exp=1", done); end
    tick();
    start = 1;
    tick();
    start = 0;
    checks++; if (out !== 4'h7) begin failures++; $display("FAIL wr_start_same_edge got=%0h exp=7", out); end
    tick(); tick();
  endtask

  task automatic test_start_stop_together();
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL startstop_idle got=b%0b/v%0b exp=b0/v0", busy, out_valid); end
  endtask

  task automatic test_len0();
    int n;
    bit seen;
    n = 0; seen = 0;
    wr(0, 4'h6);
    len = 0; loops = 3; out_ready = 1; start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid && out_ready) begin
        checks++; if (out !== 4'h6) begin failures++; $display("FAIL len0_sym cyc=%0d got=%0h exp=6", c, out); end
        n++;
      end
      tick();
      if (done) seen = 1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL len0_done_timeout got=0 exp=1"); end
    checks++; if (n !== 3) begin failures++; $display("FAIL len0_xfer_count got=%0d exp=3", n); end
    tick();
  endtask

  task automatic test_rst_mid_run();
    wr(0, 4'h1); wr(1, 4'h2); wr(2, 4'h4); wr(3, 4'h8);
    len = 3; loops = 0; out_ready = 1; start = 1;
    tick();
    start = 0;
    tick(); tick();
    #3;
    rst = 1;
    #1;
    checks++; if (out !== 4'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_out got=%0h/v%0b exp=0/v0", out, out_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_async_flags got=b%0b/d%0b exp=b0/d0", busy, done); end
    tick();
    rst = 0;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_no_done got=%0b exp=0", done); end
    len = 3; loops = 1; out_ready = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out !== 4'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL rst_table_cleared%0d got=%0h/v%0b exp=0/v1", i, out, out_valid); end
      tick();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rst_replay_done got=%0b exp=1", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_toggle();
    test_stop();
    test_wr_in_run();
    test_start_stop_together();
    test_len0();
    test_rst_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
